fc_mac: RTL and testbench

Fully-connected dot-product stage that sits directly downstream of the max-pool stage. It reads the pooled feature vector from the pooled-result SRAM (GBUFF_B) and a row-major weight matrix from a weight SRAM. It computes one signed dot product per output neuron, requantizes each result to word width, and streams the results out over a valid/ready handshake. Each run is started by a single `start` pulse from the top-level controller.

---
 rtl/fc_mac.sv | 178 +++++++++++++++++
 tb/tb_fc_mac.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fc_mac.sv
// fc_mac: streams a feature vector and a row-major weight matrix from SRAM and emits one saturated dot product per output neuron.
// Optional ReLU on the results: define FC_RELU_EN.
module fc_mac #(
  parameter int DW    = 16,
  parameter int AW    = 10,
  parameter int FBASE = 0,
  parameter int SHIFT = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_start,
  input  logic [9:0]    i_in_len,
  input  logic [9:0]    i_out_len,
  output logic [AW-1:0] o_fbuf_addr,
  input  logic [DW-1:0] i_fbuf_do,
  output logic [AW-1:0] o_wbuf_addr,
  input  logic [DW-1:0] i_wbuf_do,
  output logic          o_do_valid,
  output logic [DW-1:0] o_do,
  input  logic          i_out_ready,
  output logic          o_busy,
  output logic          o_done
);

  localparam int ACCW = 2*DW + 10;
  localparam logic signed [ACCW-1:0] SAT_MAX = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] SAT_MIN = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_DRAIN = 3'd2,
    S_OUT   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                  r_state, w_next;
  logic [9:0]              r_n, r_m, r_j, r_i;
  logic [AW-1:0]           r_wptr;
  logic signed [ACCW-1:0]  r_acc, w_acc_next;
  logic signed [2*DW-1:0]  w_prod;
  logic                    r_rv;
  logic [DW-1:0]           r_do;
  logic                    r_do_valid, r_busy, r_done;
  logic                    w_hs, w_start_ok, w_last_i;

  // Shift, clamp to the signed word range and optionally rectify.
  function automatic logic [DW-1:0] requant(input logic signed [ACCW-1:0] a);
    logic signed [ACCW-1:0] s;
    logic [DW-1:0]          r;
    s = a >>> SHIFT;
    if (s > SAT_MAX) begin
      r = SAT_MAX[DW-1:0];
    end else if (s < SAT_MIN) begin
      r = SAT_MIN[DW-1:0];
    end else begin
      r = s[DW-1:0];
    end
`ifdef FC_RELU_EN
    if (r[DW-1]) begin
      r = '0;
    end else begin
      r = r;
    end
`endif
    return r;
  endfunction

  assign w_prod     = $signed(i_fbuf_do) * $signed(i_wbuf_do);
  assign w_acc_next = r_rv ? (r_acc + {{10{w_prod[2*DW-1]}}, w_prod}) : r_acc;
  assign w_hs       = (r_state == S_OUT) && i_out_ready;
  assign w_start_ok = (i_in_len != 10'd0) && (i_out_len != 10'd0);
  assign w_last_i   = (r_i == r_m - 10'd1);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_next = w_start_ok ? S_RUN : S_DONE;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_RUN: begin
        if (r_j == r_n - 10'd1) begin
          w_next = S_DRAIN;
        end else begin
          w_next = S_RUN;
        end
      end
      S_DRAIN: w_next = S_OUT;
      S_OUT: begin
        if (w_hs) begin
          w_next = w_last_i ? S_DONE : S_RUN;
        end else begin
          w_next = S_OUT;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Counters, accumulator and registered outputs; read data lags its address by one cycle (r_rv).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_n        <= 10'd0;
      r_m        <= 10'd0;
      r_j        <= 10'd0;
      r_i        <= 10'd0;
      r_wptr     <= '0;
      r_acc      <= '0;
      r_rv       <= 1'b0;
      r_do       <= '0;
      r_do_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_rv   <= (r_state == S_RUN);
      r_busy <= (w_next != S_IDLE);
      r_done <= (w_next == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (i_start && w_start_ok) begin
            r_n    <= i_in_len;
            r_m    <= i_out_len;
            r_j    <= 10'd0;
            r_i    <= 10'd0;
            r_wptr <= '0;
            r_acc  <= '0;
          end
        end
        S_RUN: begin
          r_j    <= r_j + 10'd1;
          r_wptr <= r_wptr + 1'b1;
          r_acc  <= w_acc_next;
        end
        S_DRAIN: begin
          r_acc      <= w_acc_next;
          r_do       <= requant(w_acc_next);
          r_do_valid <= 1'b1;
        end
        S_OUT: begin
          if (w_hs) begin
            r_do_valid <= 1'b0;
            if (!w_last_i) begin
              r_i   <= r_i + 10'd1;
              r_j   <= 10'd0;
              r_acc <= '0;
            end
          end
        end
        default: begin
          r_acc <= r_acc;
        end
      endcase
    end
  end

  assign o_fbuf_addr = AW'(FBASE) + AW'(r_j);
  assign o_wbuf_addr = r_wptr;
  assign o_do        = r_do;
  assign o_do_valid  = r_do_valid;
  assign o_busy      = r_busy;
  assign o_done      = r_done;

endmodule

// File: tb/tb_fc_mac.sv
// Directed bench for fc_mac: table of dot-product runs plus backpressure, zero-length and mid-run reset sequences.
module tb_fc_mac;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_start = 1'b0;
  logic [9:0]  i_in_len = 10'd0;
  logic [9:0]  i_out_len = 10'd0;
  logic [9:0]  o_fbuf_addr, o_wbuf_addr;
  logic [15:0] i_fbuf_do, i_wbuf_do;
  logic        o_do_valid, o_busy, o_done;
  logic [15:0] o_do;
  logic        i_out_ready = 1'b0;

  logic [15:0] fmem [0:1023];
  logic [15:0] wmem [0:1023];

  int total = 0;
  int bad = 0;
  int hs_cnt = 0;

`ifdef FC_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  typedef struct {
    int n;
    int m;
    int f[6];
    int w[6];
    int e[2];
  } vec_t;

  vec_t tbl[6];

  fc_mac #(.DW(16), .AW(10), .FBASE(0), .SHIFT(0)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_in_len(i_in_len), .i_out_len(i_out_len),
    .o_fbuf_addr(o_fbuf_addr), .i_fbuf_do(i_fbuf_do), .o_wbuf_addr(o_wbuf_addr), .i_wbuf_do(i_wbuf_do),
    .o_do_valid(o_do_valid), .o_do(o_do), .i_out_ready(i_out_ready), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    i_fbuf_do <= fmem[o_fbuf_addr];
    i_wbuf_do <= wmem[o_wbuf_addr];
  end

  always @(posedge clk) begin
    if (o_do_valid && i_out_ready) hs_cnt <= hs_cnt + 1;
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic load(input vec_t v);
    for (int k = 0; k < v.n; k++) fmem[k] = v.f[k][15:0];
    for (int k = 0; k < v.n * v.m; k++) wmem[k] = v.w[k][15:0];
  endtask

  task automatic wait_valid(output int c);
    c = 0;
    while (!o_do_valid && c < 50) begin
      @(negedge clk);
      c++;
    end
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int c;
    load(v);
    @(negedge clk);
    i_in_len = v.n[9:0];
    i_out_len = v.m[9:0];
    i_start = 1'b1;
    i_out_ready = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    chk({nm, " busy"}, int'(o_busy), 1);
    for (int k = 0; k < v.m; k++) begin
      wait_valid(c);
      chk({nm, " latency"}, c, v.n + 1);
      chk({nm, " do"}, int'($signed(o_do)), v.e[k]);
      @(negedge clk);
      chk({nm, " valid fall"}, int'(o_do_valid), 0);
      chk({nm, " done"}, int'(o_done), (k == v.m - 1) ? 1 : 0);
    end
    @(negedge clk);
    chk({nm, " done end"}, int'(o_done), 0);
    chk({nm, " idle"}, int'(o_busy), 0);
  endtask

  initial begin
    int c;
    int hs0;
    vec_t v;

    tbl[0] = '{4, 1, '{1, 2, 3, 4, 0, 0}, '{1, 1, 1, 1, 0, 0}, '{10, 0}};
    tbl[1] = '{1, 1, '{3, 0, 0, 0, 0, 0}, '{-2, 0, 0, 0, 0, 0}, '{RELU ? 0 : -6, 0}};
    tbl[2] = '{4, 1, '{32767, 32767, 32767, 32767, 0, 0}, '{32767, 32767, 32767, 32767, 0, 0}, '{32767, 0}};
    tbl[3] = '{4, 1, '{32767, 32767, 32767, 32767, 0, 0}, '{-32767, -32767, -32767, -32767, 0, 0}, '{RELU ? 0 : -32768, 0}};
    tbl[4] = '{3, 2, '{1, 2, 3, 0, 0, 0}, '{1, 2, 3, -1, 0, 2}, '{14, 5}};
    tbl[5] = '{3, 1, '{-2, 3, 1, 0, 0, 0}, '{-4, 1, 5, 0, 0, 0}, '{16, 0}};

    for (int k = 0; k < 1024; k++) begin
      fmem[k] = 16'd0;
      wmem[k] = 16'd0;
    end

    repeat (2) @(negedge clk);
    chk("rst do_valid", int'(o_do_valid), 0);
    chk("rst do", int'(o_do), 0);
    chk("rst done", int'(o_done), 0);
    chk("rst busy", int'(o_busy), 0);
    chk("rst faddr", int'(o_fbuf_addr), 0);
    chk("rst waddr", int'(o_wbuf_addr), 0);
    rst = 1'b1;

    for (int t = 0; t < 6; t++) run_vec(tbl[t], $sformatf("vec%0d", t));

    // Backpressure: N=3, M=2, consumer stalls 5 cycles on the first output.
    v = '{3, 2, '{1, 1, 1, 0, 0, 0}, '{1, 2, 3, 4, 5, 6}, '{6, 15}};
    load(v);
    hs0 = hs_cnt;
    @(negedge clk);
    i_in_len = 10'd3;
    i_out_len = 10'd2;
    i_start = 1'b1;
    i_out_ready = 1'b0;
    @(negedge clk);
    i_start = 1'b0;
    c = 0;
    while (!o_do_valid && c < 50) begin
      if (c < 3) chk("bp waddr first", int'(o_wbuf_addr), c);
      @(negedge clk);
      c++;
    end
    chk("bp latency first", c, 4);
    chk("bp do first", int'($signed(o_do)), 6);
    repeat (5) begin
      @(negedge clk);
      chk("bp hold valid", int'(o_do_valid), 1);
      chk("bp hold do", int'($signed(o_do)), 6);
    end
    i_out_ready = 1'b1;
    @(negedge clk);
    chk("bp valid fall", int'(o_do_valid), 0);
    c = 0;
    while (!o_do_valid && c < 50) begin
      if (c < 3) chk("bp waddr second", int'(o_wbuf_addr), c + 3);
      @(negedge clk);
      c++;
    end
    chk("bp latency second", c, 4);
    chk("bp do second", int'($signed(o_do)), 15);
    @(negedge clk);
    chk("bp done", int'(o_done), 1);
    chk("bp handshakes", hs_cnt - hs0, 2);

    // Zero-length run.
    @(negedge clk);
    i_in_len = 10'd0;
    i_out_len = 10'd1;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    chk("zero done", int'(o_done), 1);
    chk("zero valid", int'(o_do_valid), 0);
    @(negedge clk);
    chk("zero done end", int'(o_done), 0);
    chk("zero busy", int'(o_busy), 0);
    chk("zero valid end", int'(o_do_valid), 0);

    // Reset in the middle of a run, then a clean run.
    load(tbl[0]);
    @(negedge clk);
    i_in_len = 10'd4;
    i_out_len = 10'd1;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst do_valid", int'(o_do_valid), 0);
    chk("midrst do", int'(o_do), 0);
    chk("midrst done", int'(o_done), 0);
    chk("midrst busy", int'(o_busy), 0);
    chk("midrst faddr", int'(o_fbuf_addr), 0);
    chk("midrst waddr", int'(o_wbuf_addr), 0);
    @(negedge clk);
    rst = 1'b1;
    v = '{2, 1, '{5, 5, 0, 0, 0, 0}, '{2, 3, 0, 0, 0, 0}, '{25, 0}};
    run_vec(v, "after reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
